bus_grant_sequencer: RTL and testbench

Sits between the 4-master weighted arbiter and the shared bus. It samples the arbiter's one-hot decision and locks bus ownership to that master for a full burst. It counts beats, enforces a start timeout and inserts turnaround dead cycles before ownership moves on. The arbiter's grant is a per-cycle suggestion; this block turns it into a registered, burst-stable bus grant.

---
 rtl/bus_grant_sequencer_pkg.sv | 45 ++++
 rtl/bus_grant_sequencer_if.sv | 36 +++
 rtl/bus_grant_sequencer_starve_mon.sv | 53 +++++
 rtl/bus_grant_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_bus_grant_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_grant_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// bus_grant_sequencer_pkg
// Shared definitions for the bus grant sequencer slice:
//   - seq_state_e : sequencer FSM states (IDLE/ARM/BURST/TURN)
//   - M0..M3      : one-hot master constants
//   - len_zero_is_16 : burst length decode (field value 0 means 16 beats)
//   - is_onehot / onehot_to_idx : arbiter decision helpers
// ---------------------------------------------------------------------------
package bus_grant_sequencer_pkg;

   localparam int M_COUNT     = 4;
   localparam int LEN_FIELD_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_BURST = 2'd2,
      ST_TURN  = 2'd3
   } seq_state_e;

   localparam logic [3:0] M0 = 4'b0001;
   localparam logic [3:0] M1 = 4'b0010;
   localparam logic [3:0] M2 = 4'b0100;
   localparam logic [3:0] M3 = 4'b1000;

   // A zero length field encodes the maximum burst, so the result needs 5 bits.
   function automatic logic [4:0] len_zero_is_16(input logic [3:0] len);
      return (len == 4'd0) ? 5'd16 : {1'b0, len};
   endfunction

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   // Only meaningful for a one-hot input; returns 0 for an all-zero vector.
   function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/bus_grant_sequencer_if.sv
// ---------------------------------------------------------------------------
// bus_grant_sequencer_if
// Bundles the request/arbiter/beat inputs and grant/status outputs of the
// bus grant sequencer.
//   modport slave  : the sequencer side (consumes req/arb_grant/burst_len/
//                    beat_valid, drives gnt/owner_id/busy/beat_cnt/pulses)
//   modport master : the environment side (mirror image)
// ---------------------------------------------------------------------------
interface bus_grant_sequencer_if;
   import bus_grant_sequencer_pkg::*;

   logic [M_COUNT-1:0]             req;
   logic [M_COUNT-1:0]             arb_grant;
   logic [M_COUNT*LEN_FIELD_W-1:0] burst_len;
   logic                           beat_valid;
   logic [M_COUNT-1:0]             gnt;
   logic [1:0]                     owner_id;
   logic                           busy;
   logic [4:0]                     beat_cnt;
   logic                           xfer_done;
   logic                           timeout_err;
   logic                           grant_err;
   logic [M_COUNT-1:0]             starve_flag;

   modport slave (
      input  req, arb_grant, burst_len, beat_valid,
      output gnt, owner_id, busy, beat_cnt, xfer_done, timeout_err,
             grant_err, starve_flag
   );

   modport master (
      output req, arb_grant, burst_len, beat_valid,
      input  gnt, owner_id, busy, beat_cnt, xfer_done, timeout_err,
             grant_err, starve_flag
   );
endinterface

// File: rtl/bus_grant_sequencer_starve_mon.sv
// ---------------------------------------------------------------------------
// grant_starve_mon
// Per-master starvation monitor. Each master has a 6-bit wait counter that
// counts cycles with req=1 and gnt=0 and clears when the master is granted
// or stops requesting. The flag sets when the counter reaches STARVE_LIMIT
// and clears only when the master is granted.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req          : per-master request level
//   gnt          : registered bus grant from the sequencer
//   starve_flag  : per-master starvation flag
// ---------------------------------------------------------------------------
module grant_starve_mon
   import bus_grant_sequencer_pkg::*;
#(
   parameter int NUM_M        = M_COUNT,
   parameter int STARVE_LIMIT = 60
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NUM_M-1:0] req,
   input  logic [NUM_M-1:0] gnt,
   output logic [NUM_M-1:0] starve_flag
);

   localparam logic [5:0] LIMIT      = 6'(STARVE_LIMIT);
   localparam logic [5:0] LIMIT_LAST = 6'(STARVE_LIMIT - 1);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_M; gi++) begin : g_mon
         logic [5:0] wait_cnt_reg;
         logic       flag_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               wait_cnt_reg <= 6'd0;
               flag_reg     <= 1'b0;
            end else if (gnt[gi] || !req[gi]) begin
               wait_cnt_reg <= 6'd0;
               if (gnt[gi]) flag_reg <= 1'b0;
            end else if (wait_cnt_reg != LIMIT) begin
               // Saturate at the limit so the flag cannot re-trigger by wrap.
               wait_cnt_reg <= wait_cnt_reg + 6'd1;
               if (wait_cnt_reg == LIMIT_LAST) flag_reg <= 1'b1;
            end
         end

         assign starve_flag[gi] = flag_reg;
      end
   endgenerate

endmodule

// File: rtl/bus_grant_sequencer.sv
// ---------------------------------------------------------------------------
// bus_grant_sequencer
// Turns the arbiter's per-cycle one-hot suggestion into a registered,
// burst-stable bus grant. Ownership is locked for a whole burst, the first
// beat must arrive within ARM_TIMEOUT cycles, and TURN_CYCLES dead cycles
// separate consecutive owners.
// Optional feature macro: GRANT_SEQ_STARVE_EN (starvation override; when
// undefined starve_flag is tied to 0 and arb_grant is the only source).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : bus_grant_sequencer_if.slave
//              in : req, arb_grant, burst_len, beat_valid
//              out: gnt, owner_id, busy, beat_cnt, xfer_done, timeout_err,
//                   grant_err, starve_flag
// ---------------------------------------------------------------------------
module bus_grant_sequencer
   import bus_grant_sequencer_pkg::*;
#(
   parameter int NUM_M       = M_COUNT,
   parameter int LEN_W       = LEN_FIELD_W,
   parameter int ARM_TIMEOUT = 8,
   parameter int TURN_CYCLES = 1
`ifdef GRANT_SEQ_STARVE_EN
   ,
   parameter int STARVE_LIMIT = 60
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   bus_grant_sequencer_if.slave    bus
);

   localparam logic [1:0] IDLE  = ST_IDLE;
   localparam logic [1:0] ARM   = ST_ARM;
   localparam logic [1:0] BURST = ST_BURST;
   localparam logic [1:0] TURN  = ST_TURN;

   localparam logic [7:0] ARM_LAST  = 8'(ARM_TIMEOUT - 1);
   localparam logic [7:0] TURN_LAST = 8'(TURN_CYCLES - 1);

   logic [1:0]       state_reg;
   logic [NUM_M-1:0] gnt_reg;
   logic [1:0]       owner_reg;
   logic [4:0]       len_reg;
   logic [4:0]       beat_cnt_reg;
   logic [7:0]       arm_timer_reg;
   logic [7:0]       turn_cnt_reg;
   logic             xfer_done_reg;
   logic             timeout_err_reg;
   logic             grant_err_reg;

   logic [NUM_M-1:0] starve_flag;
   logic [LEN_W-1:0] len_field [NUM_M];

   logic             arb_onehot;
   logic             cand_valid;
   logic             cand_err;
   logic [1:0]       cand_idx;
   logic [4:0]       beat_inc;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_M; gi++) begin : g_len
         assign len_field[gi] = bus.burst_len[gi*LEN_W +: LEN_W];
      end
   endgenerate

`ifdef GRANT_SEQ_STARVE_EN
   grant_starve_mon #(
      .NUM_M        (NUM_M),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_mon (
      .clk         (clk),
      .rst         (rst),
      .req         (bus.req),
      .gnt         (gnt_reg),
      .starve_flag (starve_flag)
   );
`else
   assign starve_flag = '0;
`endif

   // Candidate selection for the IDLE state.
   always_comb begin
      arb_onehot = is_onehot(bus.arb_grant);
      cand_valid = arb_onehot && ((bus.arb_grant & bus.req) != '0);
      cand_idx   = onehot_to_idx(bus.arb_grant);
      cand_err   = !arb_onehot && (bus.arb_grant != '0);
`ifdef GRANT_SEQ_STARVE_EN
      // A starving master that still requests beats the arbiter outright;
      // a malformed arbiter decision that cycle is moot, so no grant_err.
      if ((starve_flag & bus.req) != '0) begin
         cand_valid = 1'b1;
         cand_err   = 1'b0;
         for (int i = NUM_M - 1; i >= 0; i--) begin
            if (starve_flag[i] && bus.req[i]) cand_idx = 2'(i);
         end
      end
`endif
   end

   assign beat_inc = beat_cnt_reg + 5'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         gnt_reg         <= '0;
         owner_reg       <= 2'd0;
         len_reg         <= 5'd0;
         beat_cnt_reg    <= 5'd0;
         arm_timer_reg   <= 8'd0;
         turn_cnt_reg    <= 8'd0;
         xfer_done_reg   <= 1'b0;
         timeout_err_reg <= 1'b0;
         grant_err_reg   <= 1'b0;
      end else begin
         xfer_done_reg   <= 1'b0;
         timeout_err_reg <= 1'b0;
         grant_err_reg   <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (cand_valid) begin
                  state_reg     <= ARM;
                  gnt_reg       <= NUM_M'(1) << cand_idx;
                  owner_reg     <= cand_idx;
                  len_reg       <= len_zero_is_16(len_field[cand_idx]);
                  beat_cnt_reg  <= 5'd0;
                  arm_timer_reg <= 8'd0;
               end else if (cand_err) begin
                  grant_err_reg <= 1'b1;
               end
            end

            ARM: begin
               // A beat arriving on the timeout cycle still counts.
               if (bus.beat_valid) begin
                  beat_cnt_reg <= 5'd1;
                  if (len_reg == 5'd1) begin
                     xfer_done_reg <= 1'b1;
                     gnt_reg       <= '0;
                     turn_cnt_reg  <= 8'd0;
                     state_reg     <= TURN;
                  end else begin
                     state_reg <= BURST;
                  end
               end else if (arm_timer_reg == ARM_LAST) begin
                  timeout_err_reg <= 1'b1;
                  gnt_reg         <= '0;
                  turn_cnt_reg    <= 8'd0;
                  state_reg       <= TURN;
               end else begin
                  arm_timer_reg <= arm_timer_reg + 8'd1;
               end
            end

            BURST: begin
               // Gaps are legal and untimed; req[owner] is not consulted.
               if (bus.beat_valid) begin
                  beat_cnt_reg <= beat_inc;
                  if (beat_inc == len_reg) begin
                     xfer_done_reg <= 1'b1;
                     gnt_reg       <= '0;
                     turn_cnt_reg  <= 8'd0;
                     state_reg     <= TURN;
                  end
               end
            end

            default: begin // TURN
               if (turn_cnt_reg == TURN_LAST) begin
                  state_reg <= IDLE;
               end else begin
                  turn_cnt_reg <= turn_cnt_reg + 8'd1;
               end
            end
         endcase
      end
   end

   assign bus.gnt         = gnt_reg;
   assign bus.owner_id    = owner_reg;
   assign bus.busy        = (state_reg == ARM) || (state_reg == BURST);
   assign bus.beat_cnt    = beat_cnt_reg;
   assign bus.xfer_done   = xfer_done_reg;
   assign bus.timeout_err = timeout_err_reg;
   assign bus.grant_err   = grant_err_reg;
   assign bus.starve_flag = starve_flag;

endmodule

// File: tb/tb_bus_grant_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bus_grant_sequencer
// Directed bench for bus_grant_sequencer: grant latency, burst counting,
// ARM timeout, invalid arbiter decisions, 16-beat bursts with gaps,
// asynchronous reset mid-burst and, with GRANT_SEQ_STARVE_EN, the
// starvation override.
// ---------------------------------------------------------------------------
module tb_bus_grant_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass  = 0;
   int   n_fail  = 0;
   int   n_total = 0;
   int   n;

   bus_grant_sequencer_if bus_if ();

   bus_grant_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus_if.req        = 4'b0000;
      bus_if.arb_grant  = 4'b0000;
      bus_if.burst_len  = 16'h0000;
      bus_if.beat_valid = 1'b0;

      // ---------------- reset state ----------------
      tick; tick;
      check("rst_gnt",     32'(bus_if.gnt), 0);
      check("rst_owner",   32'(bus_if.owner_id), 0);
      check("rst_busy",    32'(bus_if.busy), 0);
      check("rst_beat",    32'(bus_if.beat_cnt), 0);
      check("rst_pulses",  32'({bus_if.xfer_done, bus_if.timeout_err, bus_if.grant_err}), 0);
      check("rst_starve",  32'(bus_if.starve_flag), 0);
      rst = 1'b0;

      // ---------------- master 1, 3-beat burst ----------------
      bus_if.req = 4'b0010; bus_if.arb_grant = 4'b0010; bus_if.burst_len = 16'h0030;
      tick;
      check("m1_gnt",   32'(bus_if.gnt), 32'h2);
      check("m1_busy",  32'(bus_if.busy), 1);
      check("m1_owner", 32'(bus_if.owner_id), 1);
      check("m1_beat0", 32'(bus_if.beat_cnt), 0);
      bus_if.arb_grant = 4'b0000; bus_if.beat_valid = 1'b1;
      tick;
      check("m1_beat1", 32'(bus_if.beat_cnt), 1);
      check("m1_xfer1", 32'(bus_if.xfer_done), 0);
      tick;
      check("m1_beat2", 32'(bus_if.beat_cnt), 2);
      check("m1_gnt2",  32'(bus_if.gnt), 32'h2);
      tick;
      check("m1_beat3", 32'(bus_if.beat_cnt), 3);
      check("m1_xfer3", 32'(bus_if.xfer_done), 1);
      check("m1_gnt3",  32'(bus_if.gnt), 0);
      check("m1_busy3", 32'(bus_if.busy), 0);
      bus_if.beat_valid = 1'b0; bus_if.req = 4'b0000;
      tick;
      check("m1_turn_xfer", 32'(bus_if.xfer_done), 0);
      check("m1_turn_gnt",  32'(bus_if.gnt), 0);
      check("m1_turn_beat", 32'(bus_if.beat_cnt), 3);
      $display("txn burst owner=1 len=3 beats=%0d", bus_if.beat_cnt);

      // ---------------- master 0, ARM timeout ----------------
      bus_if.req = 4'b0001; bus_if.arb_grant = 4'b0001; bus_if.burst_len = 16'h0002;
      tick;
      check("to_gnt", 32'(bus_if.gnt), 32'h1);
      bus_if.arb_grant = 4'b0000;
      for (int k = 1; k <= 7; k++) begin
         tick;
         check("to_wait_err", 32'(bus_if.timeout_err), 0);
         check("to_wait_gnt", 32'(bus_if.gnt), 32'h1);
      end
      tick;
      check("to_err",  32'(bus_if.timeout_err), 1);
      check("to_gnt0", 32'(bus_if.gnt), 0);
      check("to_xfer", 32'(bus_if.xfer_done), 0);
      check("to_busy", 32'(bus_if.busy), 0);
      bus_if.req = 4'b0000;
      tick;
      check("to_pulse_end", 32'(bus_if.timeout_err), 0);
      $display("txn timeout owner=0 after 8 cycles");

      // ---------------- invalid arbiter decisions ----------------
      bus_if.req = 4'b0110; bus_if.arb_grant = 4'b0110;
      tick;
      check("mh_grant_err", 32'(bus_if.grant_err), 1);
      check("mh_gnt",       32'(bus_if.gnt), 0);
      bus_if.arb_grant = 4'b0000; bus_if.req = 4'b0000;
      tick;
      check("mh_err_end",   32'(bus_if.grant_err), 0);
      bus_if.arb_grant = 4'b0100;
      tick;
      check("noreq_gnt",    32'(bus_if.gnt), 0);
      check("noreq_busy",   32'(bus_if.busy), 0);
      check("noreq_err",    32'(bus_if.grant_err), 0);
      bus_if.arb_grant = 4'b0000;
      tick;
      $display("txn invalid arb_grant patterns rejected");

      // ---------------- master 3, length 0 -> 16 beats with gaps ----------------
      bus_if.req = 4'b1000; bus_if.arb_grant = 4'b1000; bus_if.burst_len = 16'h0000;
      tick;
      check("m3_gnt",   32'(bus_if.gnt), 32'h8);
      check("m3_owner", 32'(bus_if.owner_id), 3);
      bus_if.arb_grant = 4'b0000;
      for (int b = 1; b <= 16; b++) begin
         bus_if.beat_valid = 1'b1;
         tick;
         check("m3_beat", 32'(bus_if.beat_cnt), 32'(b));
         check("m3_xfer", 32'(bus_if.xfer_done), (b == 16) ? 1 : 0);
         bus_if.beat_valid = 1'b0;
         if (b < 16) begin
            for (int g = 0; g < 2; g++) begin
               tick;
               check("m3_gap_to",  32'(bus_if.timeout_err), 0);
               check("m3_gap_gnt", 32'(bus_if.gnt), 32'h8);
            end
         end
      end
      check("m3_end_gnt", 32'(bus_if.gnt), 0);
      bus_if.req = 4'b0000;
      tick;
      $display("txn burst owner=3 len=16 beats=%0d", bus_if.beat_cnt);

      // ---------------- reset mid-burst ----------------
      bus_if.req = 4'b0001; bus_if.arb_grant = 4'b0001; bus_if.burst_len = 16'h0005;
      tick;
      check("rm_gnt", 32'(bus_if.gnt), 32'h1);
      bus_if.arb_grant = 4'b0000; bus_if.beat_valid = 1'b1;
      tick; tick;
      check("rm_beat2", 32'(bus_if.beat_cnt), 2);
      rst = 1'b1;
      #1;
      check("rm_async_gnt",  32'(bus_if.gnt), 0);
      check("rm_async_busy", 32'(bus_if.busy), 0);
      check("rm_async_beat", 32'(bus_if.beat_cnt), 0);
      tick;
      check("rm_no_done", 32'({bus_if.xfer_done, bus_if.timeout_err}), 0);
      rst = 1'b0;
      bus_if.beat_valid = 1'b0;
      bus_if.req = 4'b0100; bus_if.arb_grant = 4'b0100; bus_if.burst_len = 16'h0100;
      tick;
      check("rm_new_gnt",   32'(bus_if.gnt), 32'h4);
      check("rm_new_owner", 32'(bus_if.owner_id), 2);
      bus_if.arb_grant = 4'b0000; bus_if.beat_valid = 1'b1;
      tick;
      check("rm_len1_xfer", 32'(bus_if.xfer_done), 1);
      check("rm_len1_beat", 32'(bus_if.beat_cnt), 1);
      check("rm_len1_gnt",  32'(bus_if.gnt), 0);
      bus_if.beat_valid = 1'b0; bus_if.req = 4'b0000;
      tick;
      check("rm_len1_pulse", 32'(bus_if.xfer_done), 0);
      $display("txn reset abort then burst owner=2 len=1");

`ifdef GRANT_SEQ_STARVE_EN
      // ---------------- starvation override ----------------
      tick;
      bus_if.req = 4'b1001; bus_if.arb_grant = 4'b0001; bus_if.burst_len = 16'h0000;
      n = 0;
      do begin
         tick;
         n++;
      end while (!bus_if.starve_flag[3] && n < 100);
      check("sv_flag_cycles", 32'(n), 60);
      n = 0;
      while (bus_if.gnt != 4'b1000 && n < 20) begin
         tick;
         n++;
      end
      check("sv_override_gnt",   32'(bus_if.gnt), 32'h8);
      check("sv_override_owner", 32'(bus_if.owner_id), 3);
      tick;
      check("sv_flag_clear", 32'(bus_if.starve_flag[3]), 0);
      bus_if.req = 4'b0000; bus_if.arb_grant = 4'b0000;
      $display("txn starvation override owner=3");
`else
      check("starve_off", 32'(bus_if.starve_flag), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
